// File: rtl/mem_responder_pkg.sv
// Shared types and limits for the memory responder: FSM encoding, the word type,
// and the largest supported wait-state latency.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_RSP__IDLE    = 2'd0,
    MEM_RSP__WAIT    = 2'd1,
    MEM_RSP__RESPOND = 2'd2
  } mem_rsp_state_t;

  typedef logic [31:0] word_t;

  localparam int MEM_LATENCY_MAX = 15;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory port (master) and the responder (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  word_t      req_addr;
  word_t      req_wdata;
  logic [3:0] req_be;
  logic       rsp_valid;
  logic       rsp_ready;
  word_t      rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Backing word RAM with per-byte write enables and a combinational read port.
// Deliberately not reset so that backdoor preloads survive a reset pulse.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  word_t                 wdata_i,
  output word_t                 rdata_o
);

  word_t M [0:2**ADDR_WIDTH-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) M[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = M[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: decodes and commits the access at the accept
// edge, then holds the response back for LATENCY cycles before presenting it.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = MEM_RSP__IDLE;
  localparam logic [1:0] S_WAIT    = MEM_RSP__WAIT;
  localparam logic [1:0] S_RESPOND = MEM_RSP__RESPOND;
  localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  word_t      rdata_q, rdata_d;
  logic       err_q, err_d;

  logic                  accept;
  logic                  fault;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] idx;
  word_t                 mem_rdata;

  assign accept = bus.req_valid && (state_q == S_IDLE);
  assign idx    = bus.req_addr[ADDR_WIDTH+1:2];
  assign fault  = (bus.req_addr[1:0] != 2'b00) ||
                  ((bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  // Stores commit at the accept edge, so a later reset cannot undo them.
  assign mem_we = accept && bus.req_we && !fault;

  mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) memory (
    .clk    (clk),
    .we_i   (mem_we),
    .be_i   (bus.req_be),
    .addr_i (idx),
    .wdata_i(bus.req_wdata),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rdata_d = (bus.req_we || fault) ? 32'd0 : mem_rdata;
          err_d   = fault;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end else begin
            state_d = S_RESPOND;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESPOND;
      end
      S_RESPOND: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESPOND);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances at LATENCY 1, 3 and 4 share
// clock and reset; a shadow memory model predicts every response.
module tb_mem_responder;
  import mem_responder_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          busy;
  } exp_t;

  localparam int LAT [3] = '{1, 3, 4};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_ready [3];
  logic        o_req_ready [3];
  logic        o_rsp_valid [3];
  logic [31:0] o_rsp_rdata [3];
  logic        o_rsp_err   [3];

  mem_responder_if bus_l1 ();
  mem_responder_if bus_l3 ();
  mem_responder_if bus_l4 ();

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) uut_l1 (.clk(clk), .reset(reset), .bus(bus_l1));
  mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) uut_l3 (.clk(clk), .reset(reset), .bus(bus_l3));
  mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) uut_l4 (.clk(clk), .reset(reset), .bus(bus_l4));

  assign bus_l1.req_valid = req_valid[0]; assign bus_l3.req_valid = req_valid[1]; assign bus_l4.req_valid = req_valid[2];
  assign bus_l1.req_we    = req_we[0];    assign bus_l3.req_we    = req_we[1];    assign bus_l4.req_we    = req_we[2];
  assign bus_l1.req_addr  = req_addr[0];  assign bus_l3.req_addr  = req_addr[1];  assign bus_l4.req_addr  = req_addr[2];
  assign bus_l1.req_wdata = req_wdata[0]; assign bus_l3.req_wdata = req_wdata[1]; assign bus_l4.req_wdata = req_wdata[2];
  assign bus_l1.req_be    = req_be[0];    assign bus_l3.req_be    = req_be[1];    assign bus_l4.req_be    = req_be[2];
  assign bus_l1.rsp_ready = rsp_ready[0]; assign bus_l3.rsp_ready = rsp_ready[1]; assign bus_l4.rsp_ready = rsp_ready[2];
  assign o_req_ready[0] = bus_l1.req_ready; assign o_req_ready[1] = bus_l3.req_ready; assign o_req_ready[2] = bus_l4.req_ready;
  assign o_rsp_valid[0] = bus_l1.rsp_valid; assign o_rsp_valid[1] = bus_l3.rsp_valid; assign o_rsp_valid[2] = bus_l4.rsp_valid;
  assign o_rsp_rdata[0] = bus_l1.rsp_rdata; assign o_rsp_rdata[1] = bus_l3.rsp_rdata; assign o_rsp_rdata[2] = bus_l4.rsp_rdata;
  assign o_rsp_err[0]   = bus_l1.rsp_err;   assign o_rsp_err[1]   = bus_l3.rsp_err;   assign o_rsp_err[2]   = bus_l4.rsp_err;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q [$];
  logic [31:0] shadow [int];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic preload(input int s, input int idx, input logic [31:0] v);
    case (s)
      0: uut_l1.memory.M[idx] = v;
      1: uut_l3.memory.M[idx] = v;
      default: uut_l4.memory.M[idx] = v;
    endcase
    shadow[s*4096 + idx] = v;
  endtask

  function automatic logic [31:0] peek(input int s, input int idx);
    case (s)
      0: return uut_l1.memory.M[idx];
      1: return uut_l3.memory.M[idx];
      default: return uut_l4.memory.M[idx];
    endcase
  endfunction

  // Reference model: decode, fault rules and byte-enable merge into the shadow copy.
  function automatic exp_t model(input int s, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be, input int hold);
    exp_t e;
    int key;
    logic [31:0] w;
    key = s*4096 + int'(addr[11:2]);
    e.busy = LAT[s] + hold;
    e.rdata = 32'd0;
    e.err = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
    if (!e.err) begin
      w = shadow.exists(key) ? shadow[key] : 32'd0;
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        shadow[key] = w;
      end else begin
        e.rdata = w;
      end
    end
    return e;
  endfunction

  task automatic run_txn(input string tag, input int s, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int hold);
    exp_t e;
    int busy;
    bit seen;
    @(negedge clk);
    check_val({tag, ".req_ready_idle"}, 32'(o_req_ready[s]), 32'd1);
    req_we[s] = we; req_addr[s] = addr; req_wdata[s] = wdata; req_be[s] = be;
    req_valid[s] = 1'b1;
    rsp_ready[s] = (hold == 0);
    @(posedge clk);
    exp_q.push_back(model(s, we, addr, wdata, be, hold));
    #1;
    // Scramble the request fields after acceptance; the DUT must ignore them.
    req_valid[s] = 1'b0; req_we[s] = ~we; req_addr[s] = 32'hFFFF_FFF1;
    req_wdata[s] = 32'hFFFF_FFFF; req_be[s] = 4'hF;
    busy = 0;
    seen = 0;
    while (busy < 40) begin
      @(negedge clk);
      if (o_req_ready[s]) break;
      busy++;
      if (o_rsp_valid[s] && !seen) begin
        seen = 1;
        check_val({tag, ".q_nonempty"}, 32'(exp_q.size()), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '{32'hX, 1'bX, 0};
        check_val({tag, ".rdata"}, o_rsp_rdata[s], e.rdata);
        check_val({tag, ".err"}, 32'(o_rsp_err[s]), 32'(e.err));
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          busy++;
          check_val({tag, ".bp_valid"}, 32'(o_rsp_valid[s]), 32'd1);
          check_val({tag, ".bp_ready"}, 32'(o_req_ready[s]), 32'd0);
          check_val({tag, ".bp_rdata"}, o_rsp_rdata[s], e.rdata);
        end
        rsp_ready[s] = 1'b1;
      end
    end
    check_val({tag, ".rsp_seen"}, 32'(seen), 32'd1);
    if (seen) check_val({tag, ".busy_cycles"}, 32'(busy), 32'(e.busy));
    rsp_ready[s] = 1'b1;
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = 32'd0;
      req_wdata[s] = 32'd0; req_be[s] = 4'h0; rsp_ready[s] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check_val($sformatf("reset%0d.req_ready", s), 32'(o_req_ready[s]), 32'd1);
      check_val($sformatf("reset%0d.rsp_valid", s), 32'(o_rsp_valid[s]), 32'd0);
      check_val($sformatf("reset%0d.rdata", s), o_rsp_rdata[s], 32'd0);
      check_val($sformatf("reset%0d.err", s), 32'(o_rsp_err[s]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    preload(0, 0, 32'h010000EF);
    preload(1, 0, 32'hCAFEF00D);
    preload(1, 4, 32'hDEADBEEF);
    preload(1, 2, 32'h11223344);

    run_txn("l1_load", 0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    run_txn("l3_load", 1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    run_txn("l3_store_be", 1, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 0);
    run_txn("l3_load_merged", 1, 1'b0, 32'h8, 32'h0, 4'h0, 0);
    check_val("merged_model", shadow[4096 + 2], 32'h11BB33DD);
    run_txn("l3_misaligned", 1, 1'b0, 32'h2, 32'h0, 4'h0, 0);
    run_txn("l3_oob_store", 1, 1'b1, 32'h0000_1000, 32'h12345678, 4'hF, 0);
    check_val("oob_no_write", peek(1, 0), 32'hCAFEF00D);
    run_txn("l3_be0_store", 1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 0);
    check_val("be0_no_write", peek(1, 2), 32'h11BB33DD);
    run_txn("l1_backpressure", 0, 1'b0, 32'h0, 32'h0, 4'h0, 4);
    run_txn("l4_store", 2, 1'b1, 32'h40, 32'h0000_0077, 4'hF, 0);

    // Reset two cycles into a LATENCY=4 store: response dropped, write kept.
    @(negedge clk);
    req_we[2] = 1'b1; req_addr[2] = 32'h20; req_wdata[2] = 32'h5; req_be[2] = 4'hF;
    req_valid[2] = 1'b1;
    @(posedge clk);
    void'(model(2, 1'b1, 32'h20, 32'h5, 4'hF, 0));
    #1 req_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_val("midrst.rsp_valid", 32'(o_rsp_valid[2]), 32'd0);
    check_val("midrst.req_ready", 32'(o_req_ready[2]), 32'd1);
    check_val("midrst.mem_kept", peek(2, 8), 32'h5);
    @(negedge clk);
    reset = 1'b0;
    run_txn("l4_load_after_rst", 2, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    run_txn("l4_load_prev", 2, 1'b0, 32'h40, 32'h0, 4'h0, 0);

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
